// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the three request sources, the round-robin arbiter
// and the downstream consumer of the muxed data.
interface mux_rr_arbiter_if;
    logic [2:0] req;
    logic [8:0] din;
    logic [2:0] sel;
    logic [2:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] ack;
    logic       busy;

    modport slave (
        input  req, din, dout_ready,
        output sel, dout, dout_valid, ack, busy
    );

    modport master (
        output req, din, dout_ready,
        input  sel, dout, dout_valid, ack, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Three-source round-robin arbiter with a registered data mux; a grant is held
// until the consumer takes it, then the next source is picked on the same edge.
module mux_rr_arbiter (
    input logic              clk,
    input logic              rst_n,
    mux_rr_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [2:0] sel_q, sel_n;
    logic [2:0] dout_q, dout_n;
    logic       arb_en;
    logic [2:0] arb_req;
    logic [1:0] arb_ptr;
    logic [2:0] pick;
    logic       handshake;

    // One-hot winner, scanning from p upward modulo 3; p==3 behaves as 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] g;
        logic [1:0] idx;
        g   = 3'b000;
        idx = (p == 2'd3) ? 2'd0 : p;
        for (int k = 0; k < 3; k++) begin
            if (g == 3'b000 && r[idx]) g[idx] = 1'b1;
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return g;
    endfunction

    function automatic logic [2:0] field(input logic [8:0] d, input logic [2:0] g);
        return ({3{g[0]}} & d[8:6]) | ({3{g[1]}} & d[5:3]) | ({3{g[2]}} & d[2:0]);
    endfunction

    function automatic logic [1:0] ptr_after(input logic [2:0] g);
        if (g[0]) return 2'd1;
        if (g[1]) return 2'd2;
        return 2'd0;
    endfunction

    assign handshake = (state == HOLD) && bus.dout_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel_q;
        dout_n  = dout_q;
        arb_en  = 1'b0;
        arb_req = 3'b000;
        arb_ptr = ptr;
        pick    = 3'b000;

        case (state)
            IDLE: begin
                arb_en  = 1'b1;
                arb_req = bus.req;
                arb_ptr = ptr;
            end
            HOLD: begin
                if (handshake) begin
                    // The finishing winner is masked so it cannot win twice in a row.
                    ptr_n   = ptr_after(sel_q);
                    arb_en  = 1'b1;
                    arb_req = bus.req & ~sel_q;
                    arb_ptr = ptr_n;
                end
            end
        endcase

        if (arb_en) begin
            pick = rr_pick(arb_req, arb_ptr);
            if (pick != 3'b000) begin
                state_n = HOLD;
                sel_n   = pick;
                dout_n  = field(bus.din, pick);
            end else begin
                state_n = IDLE;
                sel_n   = 3'b000;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            sel_q  <= 3'b000;
            dout_q <= 3'b000;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            sel_q  <= sel_n;
            dout_q <= dout_n;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state == HOLD);
    assign bus.busy       = (state == HOLD);
    assign bus.ack        = sel_q & {3{handshake}};

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: the driver queues expected grants, a
// monitor pops and compares them at every handshake.
module tb_mux_rr_arbiter;

    typedef struct {
        logic [2:0] sel;
        logic [2:0] dout;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push_exp(input logic [2:0] s, input logic [2:0] d);
        exp_t e;
        e.sel  = s;
        e.dout = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the oldest queued grant; ack stays 0 otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.dout_valid && bus.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL hs_unexpected: got sel %b dout %0d expected no transfer at %0t",
                                 bus.sel, bus.dout, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("hs_sel", 9'(bus.sel), 9'(e.sel));
                        check("hs_dout", 9'(bus.dout), 9'(e.dout));
                        check("hs_ack", 9'(bus.ack), 9'(e.sel));
                    end
                end else begin
                    check("ack_quiet", 9'(bus.ack), 9'd0);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.req        = 3'b000;
        bus.din        = 9'o000;
        bus.dout_ready = 1'b0;
        #2;
        check("rst_sel", 9'(bus.sel), 9'd0);
        check("rst_dout", 9'(bus.dout), 9'd0);
        check("rst_valid", 9'(bus.dout_valid), 9'd0);
        check("rst_busy", 9'(bus.busy), 9'd0);
        check("rst_ack", 9'(bus.ack), 9'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request from source 2; ptr ends at 2.
        bus.req        = 3'b010;
        bus.din        = 9'o123;
        bus.dout_ready = 1'b1;
        push_exp(3'b010, 3'd2);
        step();
        check("single_sel", 9'(bus.sel), 9'b010);
        check("single_dout", 9'(bus.dout), 9'd2);
        check("single_valid", 9'(bus.dout_valid), 9'd1);
        check("single_ack", 9'(bus.ack), 9'b010);
        bus.req = 3'b000;
        step();
        check("single_idle_valid", 9'(bus.dout_valid), 9'd0);
        check("single_idle_sel", 9'(bus.sel), 9'd0);
        check("idle_dout_held", 9'(bus.dout), 9'd2);

        // Backpressure: ptr=2 so source 3 wins; grant held while din and req move.
        bus.req        = 3'b100;
        bus.din        = 9'o004;
        bus.dout_ready = 1'b0;
        push_exp(3'b100, 3'd4);
        for (int i = 0; i < 5; i++) begin
            step();
            bus.req = 3'b000;
            bus.din = 9'(i * 73 + 1);
            check("bp_sel", 9'(bus.sel), 9'b100);
            check("bp_dout", 9'(bus.dout), 9'd4);
            check("bp_valid", 9'(bus.dout_valid), 9'd1);
            check("bp_ack", 9'(bus.ack), 9'd0);
        end
        step();
        bus.dout_ready = 1'b1;
        #1;
        check("bp_release_ack", 9'(bus.ack), 9'b100);
        step();
        check("bp_done_valid", 9'(bus.dout_valid), 9'd0);
        check("bp_done_ack", 9'(bus.ack), 9'd0);

        // Round robin from ptr=0: 5,6,7,5,6,7 with no idle cycles.
        bus.req = 3'b111;
        bus.din = 9'o567;
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0:       push_exp(3'b001, 3'd5);
                1:       push_exp(3'b010, 3'd6);
                default: push_exp(3'b100, 3'd7);
            endcase
        end
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_no_gap", 9'(bus.dout_valid), 9'd1);
        end
        bus.req = 3'b000;
        step();
        check("rr_end_valid", 9'(bus.dout_valid), 9'd0);

        // Winner masking: lone held request must see one idle cycle between grants.
        bus.req = 3'b001;
        bus.din = 9'o300;
        push_exp(3'b001, 3'd3);
        push_exp(3'b001, 3'd3);
        step();
        check("mask_first_valid", 9'(bus.dout_valid), 9'd1);
        step();
        check("mask_gap_valid", 9'(bus.dout_valid), 9'd0);
        check("mask_gap_sel", 9'(bus.sel), 9'd0);
        step();
        check("mask_regrant_valid", 9'(bus.dout_valid), 9'd1);
        bus.req = 3'b000;
        step();
        check("mask_end_valid", 9'(bus.dout_valid), 9'd0);

        // Reset mid-HOLD: ptr=1 so source 2 wins; reset lands between edges.
        bus.req        = 3'b010;
        bus.din        = 9'o020;
        bus.dout_ready = 1'b0;
        step();
        check("rst_hold_sel", 9'(bus.sel), 9'b010);
        #1;
        bus.dout_ready = 1'b1;
        #1;
        check("rst_pre_ack", 9'(bus.ack), 9'b010);
        rst_n = 1'b0;
        #1;
        check("rst_mid_sel", 9'(bus.sel), 9'd0);
        check("rst_mid_valid", 9'(bus.dout_valid), 9'd0);
        check("rst_mid_ack", 9'(bus.ack), 9'd0);
        check("rst_mid_dout", 9'(bus.dout), 9'd0);
        bus.req = 3'b111;
        bus.din = 9'o567;
        step();
        #2;
        rst_n = 1'b1;
        push_exp(3'b001, 3'd5);
        step();
        check("post_rst_sel", 9'(bus.sel), 9'b001);
        bus.req = 3'b000;
        step();
        check("post_rst_idle", 9'(bus.dout_valid), 9'd0);

        step();
        check("queue_drained", 9'(exp_q.size()), 9'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
  - clk  input  1  rising-edge clock
  - rst_n  input  1  asynchronous active-low reset
  - req  input  3  request lines; req[0]=source 1, req[1]=source 2, req[2]=source 3
  - din  input  9  packed source data; din[8:6]=source 1, din[5:3]=source 2, din[2:0]=source 3
  - sel  output  3  registered mux select; 3'b001=src1, 3'b010=src2, 3'b100=src3, 3'b000=none
  - dout  output  3  registered granted data
  - dout_valid  output  1  dout/sel hold a granted transfer
  - dout_ready  input  1  consumer accepts dout
  - ack  output  3  combinational per-source completion; ack[i] = dout_valid & dout_ready & (grant==i)
  - busy  output  1  equals dout_valid
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 The block SHALL implement two states, IDLE (dout_valid=0) and HOLD (dout_valid=1).
REQ-005 The block SHALL keep a 2-bit round-robin pointer ptr in the range 0..2; priority order is ptr, ptr+1, ptr+2 (mod 3).
REQ-006 In IDLE with req!=0 at a clock edge, the block SHALL select the winner by priority order, register dout=din field of winner, set sel to the winner's code, set dout_valid=1, and enter HOLD (1-cycle latency from sampled req to dout_valid).
REQ-007 In IDLE with req==0, the block SHALL hold sel=3'b000, dout unchanged, and dout_valid=0.
REQ-008 In HOLD without handshake, sel, dout, and the winner SHALL stay stable regardless of changes to din or req, including when the winner drops req; a grant is never revoked.
REQ-009 A handshake SHALL occur at an edge where dout_valid=1 and dout_ready=1; ack[winner] SHALL be high combinationally during that cycle only.
REQ-010 On a handshake, the block SHALL set ptr to (winner+1) mod 3.
REQ-011 On a handshake, the block SHALL re-arbitrate on the same edge using req with the winner's bit masked off and the updated ptr.
REQ-012 If that re-arbitration finds a request, the block SHALL load the new grant and stay in HOLD (back-to-back transfer, one per cycle).
REQ-013 If that re-arbitration finds no request, the block SHALL return to IDLE with dout_valid=0 and sel=3'b000.
REQ-014 ack bits SHALL be one-hot or zero; ack SHALL never assert while dout_valid=0.
REQ-015 All three requests asserted continuously with dout_ready=1 SHALL produce the grant sequence src(ptr), src(ptr+1), src(ptr+2), repeating, with no source starved.
REQ-016 ptr SHALL change only on a handshake.
REQ-017 Encoding 2'b11 of ptr SHALL be unreachable; if it is ever reached, it SHALL be treated as 0.

Reset
REQ-018 While rst_n=0, the block SHALL immediately force state=IDLE, ptr=0, sel=3'b000, dout=3'b000, dout_valid=0, busy=0, and ack=3'b000, independent of clk.
REQ-019 Reset mid-HOLD SHALL discard the pending transfer without ack; the first edge after rst_n rises SHALL arbitrate from ptr=0.

Verification
REQ-020 The bench SHALL cover the single-request case: after reset, req=3'b010, din=9'o123, dout_ready=1 -> next cycle sel=3'b010, dout=3'b010 (value 2), dout_valid=1, ack=3'b010; ptr becomes 2.
REQ-021 The bench SHALL cover the round-robin case: req=3'b111, din=9'o567, dout_ready=1 held -> consecutive dout 5,6,7,5,6,7 with sel 001,010,100,... and no idle cycles.
REQ-022 The bench SHALL cover backpressure: grant src3 with din[2:0]=4, dout_ready=0 for 5 cycles while din changes and req[2] drops -> dout stays 4 and sel stays 3'b100; ack=0 until dout_ready=1, then ack=3'b100 for one cycle.
REQ-023 The bench SHALL cover winner masking: req=3'b001 held through a handshake with dout_ready=1 -> src1 is not re-granted on the handshake edge; the block returns to IDLE with dout_valid=0 for one cycle.
REQ-024 The bench SHALL cover reset mid-operation: in HOLD with sel=3'b010, assert rst_n=0 between edges -> sel=0, dout_valid=0, and ack=0 immediately; after release with req=3'b111, the first grant is src1 (sel=3'b001).
